// File: rtl/rock_spawner.sv
// rtl/rock_spawner.sv - spawns rocks into free slots at screen edges and retires expired or hit rocks
//
// Ports:
//   clk60hz      frame clock, all state changes on its rising edge
//   reset_n      asynchronous active-low reset
//   enable       game running; when low no new spawn is started
//   in_use       per-slot active flag reported by each rock instance
//   hit          per-slot one-cycle collision strobe
//   start        one-hot one-cycle spawn strobe to the chosen slot
//   rock_reset   per-slot one-cycle deactivate strobe (hit or lifetime expired)
//   initX/initY  shared spawn position, valid from PICK through CONFIRM
//   dirX/dirY    shared spawn direction, bit2 = negative, bits1:0 = magnitude
//   spawn_count  number of confirmed spawns, saturating at 255
module rock_spawner #(
   parameter int          NUM_ROCKS    = 4,
   parameter int          SPAWN_PERIOD = 90,
   parameter int          LIFETIME     = 600,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic                 clk60hz,
   input  logic                 reset_n,
   input  logic                 enable,
   input  logic [NUM_ROCKS-1:0] in_use,
   input  logic [NUM_ROCKS-1:0] hit,
   output logic [NUM_ROCKS-1:0] start,
   output logic [NUM_ROCKS-1:0] rock_reset,
   output logic [9:0]           initX,
   output logic [9:0]           initY,
   output logic [2:0]           dirX,
   output logic [2:0]           dirY,
   output logic [7:0]           spawn_count
);

   localparam int          CW            = $clog2(SPAWN_PERIOD);
   localparam logic [CW-1:0] PERIOD_RELOAD = CW'(SPAWN_PERIOD - 1);
   localparam logic [9:0]  LIFE_MAX      = 10'(LIFETIME);
   localparam logic [9:0]  LIFE_TRIP     = 10'(LIFETIME - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT    = 3'd1,
      PICK    = 3'd2,
      ISSUE   = 3'd3,
      CONFIRM = 3'd4
   } stateType;

   stateType             state;
   stateType             stateNext;
   logic [CW-1:0]        frameCnt;
   logic [CW-1:0]        frameCntNext;
   logic [NUM_ROCKS-1:0] slotSel;
   logic [NUM_ROCKS-1:0] slotSelNext;
   logic                 confirmWait;
   logic                 confirmWaitNext;
   logic                 latchBus;
   logic                 countInc;

   logic [15:0]          lfsr;
   logic [15:0]          lfsrNext;

   logic [9:0]           life [NUM_ROCKS];
   logic [NUM_ROCKS-1:0] resetNext;
   logic [NUM_ROCKS-1:0] freeMask;
   logic [NUM_ROCKS-1:0] pickOneHot;

   logic [9:0]           freeCoord;
   logic [9:0]           xFree;
   logic [9:0]           yOnce;
   logic [9:0]           yFree;
   logic [1:0]           inMag;
   logic [2:0]           sideDir;
   logic [9:0]           busX;
   logic [9:0]           busY;
   logic [2:0]           busDX;
   logic [2:0]           busDY;

   // Galois form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
   assign lfsrNext = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

   // A slot retires next cycle only while it is actually active; hits on idle slots are dropped.
   always_comb begin
      resetNext = '0;
      for (int i = 0; i < NUM_ROCKS; i++) begin
         resetNext[i] = in_use[i] & (hit[i] | (life[i] == LIFE_TRIP));
      end
   end

   // Excluding slots with a retire strobe now or next cycle keeps start and rock_reset disjoint.
   assign freeMask   = ~in_use & ~rock_reset & ~resetNext;
   // Isolate the lowest set bit: lowest-index free slot.
   assign pickOneHot = freeMask & (~freeMask + NUM_ROCKS'(1));

   // Spawn geometry from the current LFSR value.
   always_comb begin
      freeCoord = lfsr[11:2];
      xFree     = (freeCoord >= 10'd640) ? freeCoord - 10'd640 : freeCoord;
      yOnce     = (freeCoord >= 10'd480) ? freeCoord - 10'd480 : freeCoord;
      yFree     = (yOnce >= 10'd480) ? yOnce - 10'd480 : yOnce;
      inMag     = (lfsr[13:12] == 2'd0) ? 2'd1 : lfsr[13:12];
      sideDir   = {lfsr[14], 1'b0, lfsr[15]};
      busX      = xFree;
      busY      = yFree;
      busDX     = sideDir;
      busDY     = sideDir;
      case (lfsr[1:0])
         2'd0: begin
            busX  = 10'd0;
            busDX = {1'b0, inMag};
         end
         2'd1: begin
            busX  = 10'd639;
            busDX = {1'b1, inMag};
         end
         2'd2: begin
            busY  = 10'd0;
            busDY = {1'b0, inMag};
         end
         default: begin
            busY  = 10'd479;
            busDY = {1'b1, inMag};
         end
      endcase
   end

   always_comb begin
      stateNext       = state;
      frameCntNext    = frameCnt;
      slotSelNext     = slotSel;
      confirmWaitNext = confirmWait;
      latchBus        = 1'b0;
      countInc        = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               stateNext    = WAIT;
               frameCntNext = PERIOD_RELOAD;
            end
         end
         WAIT: begin
            if (!enable) begin
               stateNext = IDLE;
            end else if (frameCnt == '0) begin
               stateNext = PICK;
            end else begin
               frameCntNext = frameCnt - CW'(1);
            end
         end
         PICK: begin
            if (!enable) begin
               stateNext = IDLE;
            end else begin
               latchBus = 1'b1;
               if (|pickOneHot) begin
                  slotSelNext = pickOneHot;
                  stateNext   = ISSUE;
               end else begin
                  // No free slot: skip this attempt entirely.
                  stateNext    = WAIT;
                  frameCntNext = PERIOD_RELOAD;
               end
            end
         end
         ISSUE: begin
            stateNext       = CONFIRM;
            confirmWaitNext = 1'b0;
         end
         CONFIRM: begin
            if (|(in_use & slotSel)) begin
               countInc     = 1'b1;
               stateNext    = WAIT;
               frameCntNext = PERIOD_RELOAD;
            end else if (confirmWait) begin
               stateNext    = WAIT;
               frameCntNext = PERIOD_RELOAD;
            end else begin
               confirmWaitNext = 1'b1;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Both terms are registers, so start is glitch-free and drops at once on reset.
   assign start = (state == ISSUE) ? slotSel : '0;

   always_ff @(posedge clk60hz or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         frameCnt    <= '0;
         slotSel     <= '0;
         confirmWait <= 1'b0;
         lfsr        <= LFSR_SEED;
         rock_reset  <= '0;
         initX       <= '0;
         initY       <= '0;
         dirX        <= '0;
         dirY        <= '0;
         spawn_count <= '0;
         for (int i = 0; i < NUM_ROCKS; i++) begin
            life[i] <= '0;
         end
      end else begin
         state       <= stateNext;
         frameCnt    <= frameCntNext;
         slotSel     <= slotSelNext;
         confirmWait <= confirmWaitNext;
         lfsr        <= lfsrNext;
         rock_reset  <= resetNext;
         if (latchBus) begin
            initX <= busX;
            initY <= busY;
            dirX  <= busDX;
            dirY  <= busDY;
         end
         if (countInc && (spawn_count != 8'hFF)) begin
            spawn_count <= spawn_count + 8'd1;
         end
         for (int i = 0; i < NUM_ROCKS; i++) begin
            if (!in_use[i]) begin
               life[i] <= '0;
            end else if (life[i] != LIFE_MAX) begin
               life[i] <= life[i] + 10'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rock_spawner.sv
// tb/tb_rock_spawner.sv - directed self-checking bench for rock_spawner
module tb_rock_spawner;

   localparam logic [15:0] SEED = 16'hACE1;

   logic       clk60hz = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable  = 1'b0;
   logic [3:0] inUse   = 4'b0000;
   logic [3:0] hit     = 4'b0000;
   logic [3:0] start;
   logic [3:0] rockReset;
   logic [9:0] initX;
   logic [9:0] initY;
   logic [2:0] dirX;
   logic [2:0] dirY;
   logic [7:0] spawnCount;

   logic        echo = 1'b0;
   logic [15:0] lfsrM;
   logic [15:0] lfsrPrev;
   logic [25:0] expBus;
   int          compared   = 0;
   int          mismatched = 0;
   int          n;
   logic        anyStart;
   int          rrCount;

   rock_spawner #(
      .NUM_ROCKS   (4),
      .SPAWN_PERIOD(90),
      .LIFETIME    (600),
      .LFSR_SEED   (SEED)
   ) dut (
      .clk60hz    (clk60hz),
      .reset_n    (reset_n),
      .enable     (enable),
      .in_use     (inUse),
      .hit        (hit),
      .start      (start),
      .rock_reset (rockReset),
      .initX      (initX),
      .initY      (initY),
      .dirX       (dirX),
      .dirY       (dirY),
      .spawn_count(spawnCount)
   );

   always #5 clk60hz = ~clk60hz;

   function automatic logic [15:0] lfsrStep(input logic [15:0] v);
      return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   // Expected {initX, initY, dirX, dirY} for a given LFSR value.
   function automatic logic [25:0] busOf(input logic [15:0] v);
      logic [9:0] f, xf, yf, x, y;
      logic [1:0] m;
      logic [2:0] side, dx, dy;
      f    = v[11:2];
      xf   = (f >= 10'd640) ? f - 10'd640 : f;
      yf   = f;
      if (yf >= 10'd480) yf = yf - 10'd480;
      if (yf >= 10'd480) yf = yf - 10'd480;
      m    = (v[13:12] == 2'd0) ? 2'd1 : v[13:12];
      side = {v[14], 1'b0, v[15]};
      case (v[1:0])
         2'd0:    begin x = 10'd0;   y = yf;      dx = {1'b0, m}; dy = side;      end
         2'd1:    begin x = 10'd639; y = yf;      dx = {1'b1, m}; dy = side;      end
         2'd2:    begin x = xf;      y = 10'd0;   dx = side;      dy = {1'b0, m}; end
         default: begin x = xf;      y = 10'd479; dx = side;      dy = {1'b1, m}; end
      endcase
      return {x, y, dx, dy};
   endfunction

   // Reference LFSR; lfsrPrev holds the value seen during the previous cycle.
   always @(posedge clk60hz or negedge reset_n) begin
      if (!reset_n) begin
         lfsrM    <= SEED;
         lfsrPrev <= SEED;
      end else begin
         lfsrPrev <= lfsrM;
         lfsrM    <= lfsrStep(lfsrM);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one frame; rocks in echo mode register the start strobe seen before the edge.
   task automatic step();
      logic [3:0] s;
      s = start;
      @(posedge clk60hz);
      #1;
      if (echo) inUse = inUse | s;
   endtask

   task automatic doReset();
      reset_n = 1'b0;
      enable  = 1'b0;
      hit     = 4'b0000;
      inUse   = 4'b0000;
      echo    = 1'b0;
      step();
      step();
      reset_n = 1'b1;
      step();
   endtask

   initial begin
      // Reset state
      #12;
      check("rst_start", 32'(start), 32'h0);
      check("rst_rock_reset", 32'(rockReset), 32'h0);
      check("rst_initX", 32'(initX), 32'h0);
      check("rst_initY", 32'(initY), 32'h0);
      check("rst_dirX", 32'(dirX), 32'h0);
      check("rst_dirY", 32'(dirY), 32'h0);
      check("rst_count", 32'(spawnCount), 32'h0);

      // First spawn with echoing rocks: start on frame 92 after enable
      step();
      reset_n = 1'b1;
      step();
      enable = 1'b1;
      echo   = 1'b1;
      anyStart = 1'b0;
      for (int i = 0; i < 91; i++) begin
         step();
         anyStart = anyStart | (|start);
      end
      check("first_no_early_start", 32'(anyStart), 32'h0);
      step();
      check("first_start", 32'(start), 32'b0001);
      expBus = busOf(lfsrPrev);
      check("first_initX", 32'(initX), 32'(expBus[25:16]));
      check("first_initY", 32'(initY), 32'(expBus[15:6]));
      check("first_dirX", 32'(dirX), 32'(expBus[5:3]));
      check("first_dirY", 32'(dirY), 32'(expBus[2:0]));
      step();
      check("first_start_one_cycle", 32'(start), 32'h0);
      check("first_bus_confirm", 32'({initX, initY, dirX, dirY}), 32'(expBus));
      step();
      check("first_count", 32'(spawnCount), 32'd1);

      // Slot 2 lowest free; hit on slot 0 during PICK retires it in the same cycle as the spawn
      echo  = 1'b0;
      inUse = 4'b1011;
      anyStart = 1'b0;
      for (int i = 0; i < 90; i++) begin
         step();
         anyStart = anyStart | (|start);
      end
      check("second_no_early_start", 32'(anyStart), 32'h0);
      hit = 4'b0001;
      step();
      hit = 4'b0000;
      check("second_start", 32'(start), 32'b0100);
      check("second_hit_reset", 32'(rockReset), 32'b0001);
      expBus = busOf(lfsrPrev);
      check("second_bus", 32'({initX, initY, dirX, dirY}), 32'(expBus));
      step();
      check("second_start_off", 32'(start), 32'h0);
      check("second_bus_stable1", 32'({initX, initY, dirX, dirY}), 32'(expBus));
      step();
      check("second_bus_stable2", 32'({initX, initY, dirX, dirY}), 32'(expBus));
      step();
      check("second_timeout_count", 32'(spawnCount), 32'd1);

      // All slots busy for three periods: no start at all
      doReset();
      inUse  = 4'b1111;
      enable = 1'b1;
      anyStart = 1'b0;
      for (int i = 0; i < 280; i++) begin
         step();
         anyStart = anyStart | (|start);
      end
      check("full_no_start", 32'(anyStart), 32'h0);
      check("full_count", 32'(spawnCount), 32'd0);

      // Hit handling
      doReset();
      inUse = 4'b0100;
      step();
      step();
      hit = 4'b0100;
      step();
      hit = 4'b0000;
      check("hit_active", 32'(rockReset), 32'b0100);
      step();
      check("hit_one_cycle", 32'(rockReset), 32'h0);
      hit = 4'b0010;
      step();
      hit = 4'b0000;
      check("hit_idle_ignored", 32'(rockReset), 32'h0);

      // Lifetime expiry: exactly one retire, 600 frames after in_use rose
      doReset();
      inUse   = 4'b0001;
      rrCount = 0;
      for (int i = 0; i < 599; i++) begin
         step();
         rrCount += int'(rockReset[0]);
      end
      check("life_early", 32'(rrCount), 32'd0);
      step();
      check("life_expire", 32'(rockReset), 32'b0001);
      rrCount = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         rrCount += int'(rockReset[0]);
      end
      check("life_once", 32'(rrCount), 32'd0);

      // Rocks never respond: confirm times out, then reset mid-ISSUE
      doReset();
      enable = 1'b1;
      n = 0;
      while (start == 4'b0000 && n < 200) begin
         step();
         n++;
      end
      check("noecho_latency", 32'(n), 32'd92);
      check("noecho_start", 32'(start), 32'b0001);
      step();
      step();
      step();
      check("noecho_count", 32'(spawnCount), 32'd0);
      n = 0;
      while (start == 4'b0000 && n < 200) begin
         step();
         n++;
      end
      check("noecho_second_start", 32'(start), 32'b0001);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_start", 32'(start), 32'h0);
      check("async_rock_reset", 32'(rockReset), 32'h0);
      check("async_bus", 32'({initX, initY, dirX, dirY}), 32'h0);
      check("async_count", 32'(spawnCount), 32'h0);
      step();
      reset_n = 1'b1;
      n = 0;
      while (start == 4'b0000 && n < 200) begin
         step();
         n++;
      end
      check("resume_idle_latency", 32'(n), 32'd92);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/rock_spawner.md
ROCK_SPAWNER -- requirements
Module: rock_spawner

Interface
REQ-001 SHALL have parameter NUM_ROCKS, default 4, number of managed rock slots (2..8).
REQ-002 SHALL have parameter SPAWN_PERIOD, default 90, frames between spawn attempts (>=2).
REQ-003 SHALL have parameter LIFETIME, default 600, frames a rock lives before forced retirement.
REQ-004 SHALL have parameter LFSR_SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-005 clk60hz  input  1  frame clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  game running; low suppresses new spawns only.
REQ-008 in_use  input  NUM_ROCKS  per-slot active flag from each rock instance.
REQ-009 hit  input  NUM_ROCKS  per-slot collision strobe, one cycle.
REQ-010 start  output  NUM_ROCKS  one-hot spawn strobe to rock slots.
REQ-011 rock_reset  output  NUM_ROCKS  per-slot deactivate strobe, one cycle.
REQ-012 initX, initY  output  10 each  shared spawn position bus.
REQ-013 dirX, dirY  output  3 each  shared direction bus; bit2 = negative, bits1:0 = magnitude.
REQ-014 spawn_count  output  8  total successful spawns, saturating at 255.

Function
REQ-015 SHALL implement states IDLE, WAIT, PICK, ISSUE, CONFIRM.
REQ-016 IDLE -> WAIT when enable=1, loading frame counter with SPAWN_PERIOD-1.
REQ-017 WAIT: counter decrements each cycle; at 0 -> PICK; enable=0 in any state except ISSUE/CONFIRM -> IDLE.
REQ-018 PICK: select lowest-index slot with in_use=0 and no rock_reset pending this cycle; none free -> WAIT reloaded (attempt skipped, no retry until next period).
REQ-019 PICK SHALL latch initX/initY/dirX/dirY from the LFSR; buses hold stable from PICK through CONFIRM.
REQ-020 ISSUE: start[slot]=1 for exactly one cycle, all other start bits 0 -> CONFIRM.
REQ-021 CONFIRM: in_use[slot]=1 -> increment spawn_count, -> WAIT reloaded; after 2 cycles without it -> WAIT reloaded, count unchanged.
REQ-022 LFSR: 16-bit Galois, taps 16,14,13,11, advances every cycle regardless of state.
REQ-023 Edge select = lfsr[1:0]: 0 left (X=0), 1 right (X=639), 2 top (Y=0), 3 bottom (Y=479).
REQ-024 Free coordinate = lfsr[11:2] modulo range, implemented as subtract-once: X>=640 -> X-640; Y>=480 -> Y-480 (Y subtract repeated at most twice, 10-bit unsigned).
REQ-025 Inward axis direction SHALL point into screen (left/top sign 0, right/bottom sign 1), magnitude lfsr[13:12], 0 forced to 1.
REQ-026 Other axis: sign lfsr[14], magnitude lfsr[15] ? 2'd1 : 2'd0.
REQ-027 Per-slot lifetime counter (10-bit): cleared while in_use=0, increments while in_use=1, saturates at LIFETIME.
REQ-028 rock_reset[i]=1 for one cycle when in_use[i]=1 and (hit[i]=1 or lifetime[i] reaches LIFETIME-1); registered output.
REQ-029 hit[i] while in_use[i]=0 SHALL be ignored.
REQ-030 start[i] and rock_reset[i] SHALL never both be 1 in the same cycle; start always has at most one bit set.
REQ-031 Simultaneous hit on one slot and spawn into another SHALL both proceed same cycle.

Reset
REQ-032 reset_n=0 SHALL immediately force: state IDLE, start=0, rock_reset=0, initX=initY=0, dirX=dirY=0, spawn_count=0, lifetime counters 0, LFSR=LFSR_SEED.
REQ-033 Reset asserted mid-ISSUE/CONFIRM SHALL abort without spawn_count change; release resumes in IDLE.

Verification
REQ-034 enable=1, in_use=0000, model rocks echo start -> first start=0001 at cycle SPAWN_PERIOD+2 after enable, spawn_count=1.
REQ-035 in_use=1111, enable=1 -> no start bit ever, spawn_count stays 0 across 3 periods.
REQ-036 in_use=1011 at PICK -> start=0100; buses stable PICK..CONFIRM; inward dir sign matches edge, magnitude !=0.
REQ-037 slot 2 active, hit[2]=1 one cycle -> rock_reset=0100 next cycle; hit[1] with in_use[1]=0 -> no rock_reset.
REQ-038 slot 0 held active with LIFETIME=600 -> rock_reset[0] once, 600 cycles after in_use[0] rose.
REQ-039 rocks never raise in_use -> CONFIRM times out in 2 cycles, spawn_count=0; reset_n pulsed during ISSUE -> all outputs 0 asynchronously.
